avalon_packet_arbiter: RTL and testbench
========================================

// Module: avalon_packet_arbiter
//
// PURPOSE
//   Shares one Avalon-ST output stream between NUM_INPUTS packet sources.
//   Arbitration is packet-level round-robin: once a source wins, it keeps the output until its eop beat transfers.
//   Sits downstream of per-source avalon_enforcer instances, which guarantee sop/eop framing on every input.
//   Drives a single shared consumer.
//
// PARAMETERS
//   DATA_WIDTH_IN_BYTES  16  bytes per data beat; EW = $clog2(DATA_WIDTH_IN_BYTES)
//   NUM_INPUTS           4   number of requesting streams (>=2); IW = $clog2(NUM_INPUTS)
//
// PORTS
//   clk               in   1                           single clock, all logic on posedge
//   rst               in   1                           asynchronous, active-high reset
//   in_valid          in   NUM_INPUTS                  per-source valid
//   in_rdy            out  NUM_INPUTS                  per-source ready (beat accepted when valid&rdy)
//   in_sop            in   NUM_INPUTS                  per-source start of packet
//   in_eop            in   NUM_INPUTS                  per-source end of packet
//   in_data           in   NUM_INPUTS*DATA_WIDTH_IN_BYTES*8  source i at [i*W +: W]
//   in_empty          in   NUM_INPUTS*EW               source i at [i*EW +: EW]
//   out_valid         out  1                           shared output valid
//   out_rdy           in   1                           shared output ready from consumer
//   out_sop           out  1                           shared output start of packet
//   out_eop           out  1                           shared output end of packet
//   out_data          out  DATA_WIDTH_IN_BYTES*8       shared output data
//   out_empty         out  EW                          shared output empty
//   grant_idx         out  IW                          index of the currently/last granted source
//   busy              out  1                           1 while in LOCKED
//   stray_beat_indi   out  1                           1-cycle pulse: stray beat was discarded
//
// BEHAVIOUR
//   Reset values
//     state=IDLE, rr_ptr=0, grant_idx=0, stray_beat_indi=0.
//     All outputs low/zero; no transfer occurs while rst=1.
//   IDLE
//     - out_valid=0; out_sop/out_eop/out_data/out_empty=0.
//     - Request vector = in_valid & in_sop.
//     - Winner = first set bit searching upward from rr_ptr, wrapping at NUM_INPUTS-1 -> 0.
//     - If any request: grant_idx<=winner; state<=LOCKED.
//     - in_rdy[winner] stays 0 in IDLE; its sop beat is transferred in LOCKED.
//     - Stray beats (valid & ~sop) on any source: in_rdy[i]=1 for that source, so the beat is discarded.
//       stray_beat_indi<=1 on the next cycle (registered OR over sources); no other effect.
//     - A source presenting valid&sop never gets in_rdy in IDLE.
//   LOCKED (g = grant_idx)
//     - out_valid/sop/eop/data/empty = in_*[g] (combinational mux, zero added latency).
//     - in_rdy[g]=out_rdy; in_rdy of all other sources = 0.
//     - Transfer = out_valid & out_rdy.
//     - Transfer with out_eop=1: state<=IDLE; rr_ptr<=(g==NUM_INPUTS-1)?0:g+1.
//     - out_rdy=0: everything held; no beat dropped or duplicated.
//     - in_valid[g]=0 mid-packet: out_valid=0; lock is retained.
//     - Framing inside the locked packet is not re-checked (enforcer guarantees it).
//   Latency / throughput
//     - One arbitration bubble per packet: sop beat appears on the output the cycle after the grant decision.
//     - Single-beat packet (sop&eop): LOCKED for exactly one transfer, then IDLE.
//   Outputs
//     - busy = (state==LOCKED).
//     - grant_idx holds its last value while in IDLE.
//   Reset mid-packet
//     - Returns to IDLE immediately; rr_ptr=0.
//     - Downstream sees a truncated packet; recovery belongs to the downstream enforcer.
//   Simultaneous requests
//     - Resolved strictly by rr_ptr order.
//     - Fairness: a continuously requesting source waits at most NUM_INPUTS-1 packets.
//
// TESTING
//   1. Reset, all in_valid=0 -> out_valid=0, in_rdy=0, busy=0, grant_idx=0.
//   2. Src0 sends 3-beat pkt (data 8'h22 x16, last empty=4), out_rdy=1.
//      -> busy next cycle; 3 out beats; eop with empty=4; IDLE after the 3rd beat.
//   3. All 4 sources hold 1-beat sop&eop packets continuously.
//      -> grants 0,1,2,3,0,1...; one idle cycle between packets.
//   4. Src2 4-beat pkt, out_rdy pattern 1,0,0,1,0,1,1.
//      -> in_rdy[2] mirrors out_rdy; exactly 4 beats out in order; none lost or duplicated.
//   5. IDLE, src1 valid with sop=0.
//      -> in_rdy[1]=1, stray_beat_indi pulses 1 cycle, out_valid stays 0.
//   6. rst=1 during beat 2 of src3 pkt.
//      -> out_valid=0 immediately; after release, rr_ptr=0 (src0 wins over src3 if both request).

Source files
------------

// File: rtl/avalon_packet_arbiter_if.sv
// Avalon-ST bundle between NUM_INPUTS packet sources and one shared consumer.
// The slave modport is the arbiter's view; the master modport drives sources and the consumer ready.
interface avalon_packet_arbiter_if #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned NUM_INPUTS          = 4
);
  localparam int unsigned W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int unsigned EW = ($clog2(DATA_WIDTH_IN_BYTES) > 0) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [NUM_INPUTS-1:0]    in_valid;
  logic [NUM_INPUTS-1:0]    in_rdy;
  logic [NUM_INPUTS-1:0]    in_sop;
  logic [NUM_INPUTS-1:0]    in_eop;
  logic [NUM_INPUTS*W-1:0]  in_data;
  logic [NUM_INPUTS*EW-1:0] in_empty;
  logic                     out_valid;
  logic                     out_rdy;
  logic                     out_sop;
  logic                     out_eop;
  logic [W-1:0]             out_data;
  logic [EW-1:0]            out_empty;

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, in_empty, out_rdy,
    output in_rdy, out_valid, out_sop, out_eop, out_data, out_empty
  );

  modport master (
    output in_valid, in_sop, in_eop, in_data, in_empty, out_rdy,
    input  in_rdy, out_valid, out_sop, out_eop, out_data, out_empty
  );
endinterface

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter: one Avalon-ST output shared by NUM_INPUTS framed sources.
// A winner keeps the output until its eop beat transfers; stray non-sop beats in IDLE are discarded.
module avalon_packet_arbiter #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
  parameter int unsigned NUM_INPUTS          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  avalon_packet_arbiter_if.slave bus,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                  busy,
  output logic                  stray_beat_indi
);
  localparam int unsigned W  = DATA_WIDTH_IN_BYTES * 8;
  localparam int unsigned EW = ($clog2(DATA_WIDTH_IN_BYTES) > 0) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int unsigned IW = $clog2(NUM_INPUTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [IW-1:0]         rr_ptr;
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] stray;
  logic [IW-1:0]         winner;
  logic                  found;

  logic [NUM_INPUTS-1:0] in_rdy_c;
  logic                  out_valid_c;
  logic                  out_sop_c;
  logic                  out_eop_c;
  logic [W-1:0]          out_data_c;
  logic [EW-1:0]         out_empty_c;

  assign req   = bus.in_valid & bus.in_sop;
  assign stray = bus.in_valid & ~bus.in_sop;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NUM_INPUTS)) idx = idx - int'(NUM_INPUTS);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  // Output mux and ready steering; everything quiet while in reset.
  always_comb begin
    in_rdy_c    = '0;
    out_valid_c = 1'b0;
    out_sop_c   = 1'b0;
    out_eop_c   = 1'b0;
    out_data_c  = '0;
    out_empty_c = '0;
    if (!rst) begin
      if (state == IDLE) begin
        in_rdy_c = stray;
      end else begin
        out_valid_c         = bus.in_valid[grant_idx];
        out_sop_c           = bus.in_sop[grant_idx];
        out_eop_c           = bus.in_eop[grant_idx];
        out_data_c          = bus.in_data[int'(grant_idx)*W +: W];
        out_empty_c         = bus.in_empty[int'(grant_idx)*EW +: EW];
        in_rdy_c[grant_idx] = bus.out_rdy;
      end
    end
  end

  assign bus.in_rdy    = in_rdy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sop   = out_sop_c;
  assign bus.out_eop   = out_eop_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_empty = out_empty_c;
  assign busy          = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      stray_beat_indi <= 1'b0;
    end else begin
      stray_beat_indi <= (state == IDLE) && (|stray);
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx <= winner;
            state     <= LOCKED;
          end
        end
        LOCKED: begin
          if (out_valid_c && bus.out_rdy && out_eop_c) begin
            state  <= IDLE;
            rr_ptr <= (grant_idx == IW'(NUM_INPUTS - 1)) ? '0 : grant_idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Directed table-driven bench for avalon_packet_arbiter (4 sources, 16-byte beats).
// Source i carries data byte (b + 16*i) replicated and empty (emp + i) for each vector.
module tb_avalon_packet_arbiter;
  localparam int unsigned NB = 16;
  localparam int unsigned NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_idx;
  logic       busy;
  logic       stray_beat_indi;

  avalon_packet_arbiter_if #(.DATA_WIDTH_IN_BYTES(NB), .NUM_INPUTS(NI)) bus_if ();

  avalon_packet_arbiter #(.DATA_WIDTH_IN_BYTES(NB), .NUM_INPUTS(NI)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if.slave),
    .grant_idx       (grant_idx),
    .busy            (busy),
    .stray_beat_indi (stray_beat_indi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v, s, e;
    logic       r;
    logic [7:0] b;
    logic [3:0] em;
    logic       ov, os, oe;
    logic [7:0] ob;
    logic [3:0] oem;
    logic [3:0] irdy;
    logic       bsy;
    logic [1:0] g;
    logic       st;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] s, logic [3:0] e, logic r,
                              logic [7:0] b, logic [3:0] em,
                              logic ov, logic os, logic oe, logic [7:0] ob, logic [3:0] oem,
                              logic [3:0] irdy, logic bsy, logic [1:0] g, logic st);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.r = r; t.b = b; t.em = em;
    t.ov = ov; t.os = os; t.oe = oe; t.ob = ob; t.oem = oem;
    t.irdy = irdy; t.bsy = bsy; t.g = g; t.st = st;
    return t;
  endfunction

  task automatic drive(logic [3:0] v, logic [3:0] s, logic [3:0] e, logic r,
                       logic [7:0] b, logic [3:0] em);
    bus_if.in_valid = v;
    bus_if.in_sop   = s;
    bus_if.in_eop   = e;
    bus_if.out_rdy  = r;
    for (int i = 0; i < int'(NI); i++) begin
      bus_if.in_data[i*NB*8 +: NB*8] = {NB{8'(b + 8'(16 * i))}};
      bus_if.in_empty[i*4 +: 4]      = 4'(em + 4'(i));
    end
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_obs();
    return 128'({bus_if.out_valid, bus_if.out_sop, bus_if.out_eop, bus_if.out_data[7:0],
                 bus_if.out_empty, bus_if.in_rdy, busy, grant_idx, stray_beat_indi});
  endfunction

  function automatic logic [127:0] pack_exp(vec_t t);
    return 128'({t.ov, t.os, t.oe, t.ob, t.oem, t.irdy, t.bsy, t.g, t.st});
  endfunction

  initial begin
    // Reset and source-0 3-beat packet
    vecs.push_back(mk(4'h0,4'h0,4'h0,1,8'h00,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd0,0));
    vecs.push_back(mk(4'h1,4'h1,4'h0,1,8'h22,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd0,0));
    vecs.push_back(mk(4'h1,4'h1,4'h0,1,8'h22,4'd0, 1,1,0,8'h22,4'd0,4'h1,1,2'd0,0));
    vecs.push_back(mk(4'h1,4'h0,4'h0,1,8'h22,4'd0, 1,0,0,8'h22,4'd0,4'h1,1,2'd0,0));
    vecs.push_back(mk(4'h1,4'h0,4'h1,1,8'h22,4'd4, 1,0,1,8'h22,4'd4,4'h1,1,2'd0,0));
    vecs.push_back(mk(4'h0,4'h0,4'h0,1,8'h00,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd0,0));
    // All sources request single-beat packets; rr_ptr starts at 1
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd0,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 1,1,1,8'h50,4'd1,4'h2,1,2'd1,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd1,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 1,1,1,8'h60,4'd2,4'h4,1,2'd2,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd2,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 1,1,1,8'h70,4'd3,4'h8,1,2'd3,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd3,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 1,1,1,8'h40,4'd0,4'h1,1,2'd0,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd0,0));
    vecs.push_back(mk(4'hF,4'hF,4'hF,1,8'h40,4'd0, 1,1,1,8'h50,4'd1,4'h2,1,2'd1,0));
    vecs.push_back(mk(4'h0,4'h0,4'h0,1,8'h00,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd1,0));
    // Source-2 4-beat packet under backpressure 1,0,0,1,0,1,1
    vecs.push_back(mk(4'h4,4'h4,4'h0,1,8'h80,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd1,0));
    vecs.push_back(mk(4'h4,4'h4,4'h0,1,8'h80,4'd0, 1,1,0,8'hA0,4'd2,4'h4,1,2'd2,0));
    vecs.push_back(mk(4'h4,4'h0,4'h0,0,8'h81,4'd0, 1,0,0,8'hA1,4'd2,4'h0,1,2'd2,0));
    vecs.push_back(mk(4'h4,4'h0,4'h0,0,8'h81,4'd0, 1,0,0,8'hA1,4'd2,4'h0,1,2'd2,0));
    vecs.push_back(mk(4'h4,4'h0,4'h0,1,8'h81,4'd0, 1,0,0,8'hA1,4'd2,4'h4,1,2'd2,0));
    vecs.push_back(mk(4'h4,4'h0,4'h0,0,8'h82,4'd0, 1,0,0,8'hA2,4'd2,4'h0,1,2'd2,0));
    vecs.push_back(mk(4'h4,4'h0,4'h0,1,8'h82,4'd0, 1,0,0,8'hA2,4'd2,4'h4,1,2'd2,0));
    vecs.push_back(mk(4'h4,4'h0,4'h4,1,8'h83,4'd5, 1,0,1,8'hA3,4'd7,4'h4,1,2'd2,0));
    vecs.push_back(mk(4'h0,4'h0,4'h0,1,8'h00,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd2,0));
    // Stray beat on source 1 in IDLE
    vecs.push_back(mk(4'h2,4'h0,4'h0,1,8'h11,4'd0, 0,0,0,8'h00,4'd0,4'h2,0,2'd2,0));
    vecs.push_back(mk(4'h0,4'h0,4'h0,1,8'h00,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd2,1));
    vecs.push_back(mk(4'h0,4'h0,4'h0,1,8'h00,4'd0, 0,0,0,8'h00,4'd0,4'h0,0,2'd2,0));

    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 1'b1, 8'h00, 4'd0);
    #1;
    chk("reset_out_valid", 128'(bus_if.out_valid), 128'(0));
    chk("reset_in_rdy",    128'(bus_if.in_rdy),    128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].v, vecs[n].s, vecs[n].e, vecs[n].r, vecs[n].b, vecs[n].em);
      #1;
      chk($sformatf("vec%0d", n), pack_obs(), pack_exp(vecs[n]));
    end

    // Reset in the middle of a source-3 packet (rr_ptr is 3 here)
    @(negedge clk);
    drive(4'h8, 4'h8, 4'h0, 1'b1, 8'h90, 4'd0);
    @(negedge clk);
    #1;
    chk("src3_grant", 128'(grant_idx), 128'(3));
    chk("src3_sop_data", 128'(bus_if.out_data[7:0]), 128'(8'hC0));
    @(negedge clk);
    drive(4'h8, 4'h0, 4'h0, 1'b1, 8'h91, 4'd0);
    #1;
    chk("src3_beat2_valid", 128'(bus_if.out_valid), 128'(1));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(bus_if.out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_grant", 128'(grant_idx), 128'(0));
    chk("midrst_in_rdy", 128'(bus_if.in_rdy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(4'h9, 4'h9, 4'h0, 1'b1, 8'h90, 4'd0);
    #1;
    chk("postrst_idle_rdy", 128'(bus_if.in_rdy), 128'(0));
    @(negedge clk);
    #1;
    chk("postrst_src0_wins", 128'(grant_idx), 128'(0));
    chk("postrst_busy", 128'(busy), 128'(1));
    chk("postrst_data", 128'(bus_if.out_data[7:0]), 128'(8'h90));
    chk("postrst_in_rdy", 128'(bus_if.in_rdy), 128'(4'h1));
    // Source 0 stalls mid-packet while source 3 still requests: lock held
    @(negedge clk);
    drive(4'h8, 4'h8, 4'h0, 1'b1, 8'h90, 4'd0);
    #1;
    chk("stall_out_valid", 128'(bus_if.out_valid), 128'(0));
    chk("stall_busy", 128'(busy), 128'(1));
    chk("stall_grant", 128'(grant_idx), 128'(0));
    chk("stall_in_rdy", 128'(bus_if.in_rdy), 128'(4'h1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
